// File: rtl/grid_mover_pkg.sv
// Shared types for the grid mover: facing codes, FSM states and direction helpers.
package grid_mover_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOP  = 1'b1
    } state_e;

    function automatic logic dir_is_y(input dir_e d);
        return (d == DIR_UP) || (d == DIR_DOWN);
    endfunction

    // Up and left walk toward smaller coordinates.
    function automatic logic dir_is_neg(input dir_e d);
        return (d == DIR_UP) || (d == DIR_LEFT);
    endfunction

endpackage

// File: rtl/grid_mover_if.sv
// Game-control / renderer side bundle of the grid mover.
interface grid_mover_if #(
    parameter int COORD_W = 10
);
    logic               i_up;
    logic               i_down;
    logic               i_left;
    logic               i_right;
    logic               i_tick;
    logic               i_enable;
    logic               i_respawn;
    logic [COORD_W-1:0] o_x;
    logic [COORD_W-1:0] o_y;
    logic [1:0]         o_dir;
    logic               o_moving;
    logic               o_hop_done;
    logic               o_bump;

    modport master (
        output i_up, i_down, i_left, i_right, i_tick, i_enable, i_respawn,
        input  o_x, o_y, o_dir, o_moving, o_hop_done, o_bump
    );

    modport slave (
        input  i_up, i_down, i_left, i_right, i_tick, i_enable, i_respawn,
        output o_x, o_y, o_dir, o_moving, o_hop_done, o_bump
    );
endinterface

// File: rtl/debounce_switch.sv
// Two-flop synchroniser plus stability counter for one raw button.
module debounce_switch #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam logic [15:0] LIMIT_C = 16'(CYCLES - 1);

    logic        sync1_r;
    logic        sync2_r;
    logic        stable_r;
    logic [15:0] cnt_r;

    // Reset adopts the current raw level so a held button is not seen as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= raw;
            sync2_r  <= raw;
            stable_r <= raw;
            cnt_r    <= 16'd0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= 16'd0;
            end else if (cnt_r == LIMIT_C) begin
                stable_r <= sync2_r;
                cnt_r    <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    assign level = stable_r;
endmodule

// File: rtl/key_repeat.sv
// Press edge detect plus tick-paced auto-repeat; emits single-cycle move requests.
module key_repeat #(
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic tick,
    output logic req
);
    localparam logic [15:0] DELAY_C  = 16'(REPEAT_DELAY);
    localparam logic [15:0] PERIOD_C = 16'(REPEAT_DELAY + REPEAT_RATE);

    logic        prev_r;
    logic        req_r;
    logic        req_n_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_n_s;
    logic [15:0] cnt_inc_s;

    // Counter wraps back to DELAY after each repeat so later repeats land every RATE ticks.
    always_comb begin
        cnt_n_s   = cnt_r;
        req_n_s   = 1'b0;
        cnt_inc_s = cnt_r + 16'd1;
        if (!level) begin
            cnt_n_s = 16'd0;
        end else if (!prev_r) begin
            req_n_s = 1'b1;
            cnt_n_s = 16'd0;
        end else if (tick && (DELAY_C != 16'd0)) begin
            if (cnt_inc_s == PERIOD_C) begin
                req_n_s = 1'b1;
                cnt_n_s = DELAY_C;
            end else if (cnt_inc_s == DELAY_C) begin
                req_n_s = 1'b1;
                cnt_n_s = cnt_inc_s;
            end else begin
                cnt_n_s = cnt_inc_s;
            end
        end else begin
            cnt_n_s = cnt_r;
        end
    end

    // Edge register, repeat counter and request pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= level;
            cnt_r  <= 16'd0;
            req_r  <= 1'b0;
        end else begin
            prev_r <= level;
            cnt_r  <= cnt_n_s;
            req_r  <= req_n_s;
        end
    end

    assign req = req_r;
endmodule

// File: rtl/grid_mover.sv
// Grid-locked sprite mover: button arbitration, hop FSM and position datapath.
module grid_mover
    import grid_mover_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int STEP         = 32,
    parameter int HOP_STEPS    = 4,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 608,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 448,
    parameter int START_X      = 320,
    parameter int START_Y      = 448,
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 6,
    parameter int DB_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    grid_mover_if.slave bus
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [COORD_W:0]   STEP_C    = CW1'(STEP);
    localparam logic [COORD_W:0]   X_MIN_C   = CW1'(X_MIN);
    localparam logic [COORD_W:0]   X_MAX_C   = CW1'(X_MAX);
    localparam logic [COORD_W:0]   Y_MIN_C   = CW1'(Y_MIN);
    localparam logic [COORD_W:0]   Y_MAX_C   = CW1'(Y_MAX);
    localparam logic [COORD_W-1:0] HSTEP_C   = COORD_W'(STEP / HOP_STEPS);
    localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);

    logic [3:0] raw_s;
    logic [3:0] lvl_s;
    logic [3:0] req_s;

    assign raw_s = {bus.i_right, bus.i_left, bus.i_down, bus.i_up};

    for (genvar g = 0; g < 4; g++) begin : g_key
        debounce_switch #(.CYCLES(DB_CYCLES)) u_db (
            .clk(clk), .reset(reset), .raw(raw_s[g]), .level(lvl_s[g])
        );
        key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep (
            .clk(clk), .reset(reset), .level(lvl_s[g]), .tick(bus.i_tick), .req(req_s[g])
        );
    end

    state_e             state_r, state_n_s;
    dir_e               dir_r, dir_n_s, req_dir_s;
    logic [COORD_W-1:0] x_r, x_n_s, y_r, y_n_s, tgt_r, tgt_n_s;
    logic [COORD_W-1:0] acur_s, astep_s;
    logic [COORD_W:0]   cur_s, cand_s, lo_s, hi_s;
    logic               req_any_s, in_range_s;
    logic               moving_r, moving_n_s, hop_done_r, hop_done_n_s, bump_r, bump_n_s;

    // Fixed priority up > down > left > right; losers are dropped.
    always_comb begin
        req_any_s = 1'b1;
        req_dir_s = DIR_UP;
        if (req_s[0]) begin
            req_dir_s = DIR_UP;
        end else if (req_s[1]) begin
            req_dir_s = DIR_DOWN;
        end else if (req_s[2]) begin
            req_dir_s = DIR_LEFT;
        end else if (req_s[3]) begin
            req_dir_s = DIR_RIGHT;
        end else begin
            req_any_s = 1'b0;
        end
    end

    // Target is computed one bit wider so an underflow shows up as an out-of-range value.
    always_comb begin
        cur_s = dir_is_y(req_dir_s) ? {1'b0, y_r} : {1'b0, x_r};
        if (dir_is_neg(req_dir_s)) begin
            cand_s = cur_s - STEP_C;
        end else begin
            cand_s = cur_s + STEP_C;
        end
        if (dir_is_y(req_dir_s)) begin
            lo_s = Y_MIN_C;
            hi_s = Y_MAX_C;
        end else begin
            lo_s = X_MIN_C;
            hi_s = X_MAX_C;
        end
        in_range_s = (cand_s >= lo_s) && (cand_s <= hi_s);
        acur_s     = dir_is_y(dir_r) ? y_r : x_r;
        if (dir_is_neg(dir_r)) begin
            astep_s = acur_s - HSTEP_C;
        end else begin
            astep_s = acur_s + HSTEP_C;
        end
    end

    // Next-state and output decode; respawn overrides everything.
    always_comb begin
        state_n_s    = state_r;
        x_n_s        = x_r;
        y_n_s        = y_r;
        tgt_n_s      = tgt_r;
        dir_n_s      = dir_r;
        moving_n_s   = moving_r;
        hop_done_n_s = 1'b0;
        bump_n_s     = 1'b0;
        if (bus.i_respawn) begin
            state_n_s  = ST_IDLE;
            x_n_s      = START_X_C;
            y_n_s      = START_Y_C;
            dir_n_s    = DIR_UP;
            moving_n_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s && bus.i_enable) begin
                        dir_n_s = req_dir_s;
                        if (in_range_s) begin
                            tgt_n_s    = cand_s[COORD_W-1:0];
                            moving_n_s = 1'b1;
                            state_n_s  = ST_HOP;
                        end else begin
                            bump_n_s = 1'b1;
                        end
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_HOP: begin
                    if (bus.i_tick) begin
                        if (dir_is_y(dir_r)) begin
                            y_n_s = astep_s;
                        end else begin
                            x_n_s = astep_s;
                        end
                        if (astep_s == tgt_r) begin
                            moving_n_s   = 1'b0;
                            hop_done_n_s = 1'b1;
                            state_n_s    = ST_IDLE;
                        end else begin
                            state_n_s = ST_HOP;
                        end
                    end else begin
                        state_n_s = ST_HOP;
                    end
                end
                default: begin
                    state_n_s  = ST_IDLE;
                    moving_n_s = 1'b0;
                end
            endcase
        end
    end

    // State, position and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            x_r        <= START_X_C;
            y_r        <= START_Y_C;
            tgt_r      <= START_X_C;
            dir_r      <= DIR_UP;
            moving_r   <= 1'b0;
            hop_done_r <= 1'b0;
            bump_r     <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            x_r        <= x_n_s;
            y_r        <= y_n_s;
            tgt_r      <= tgt_n_s;
            dir_r      <= dir_n_s;
            moving_r   <= moving_n_s;
            hop_done_r <= hop_done_n_s;
            bump_r     <= bump_n_s;
        end
    end

    assign bus.o_x        = x_r;
    assign bus.o_y        = y_r;
    assign bus.o_dir      = dir_r;
    assign bus.o_moving   = moving_r;
    assign bus.o_hop_done = hop_done_r;
    assign bus.o_bump     = bump_r;
endmodule
